// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the D-stage hazard scoreboard.
//   REG_AW_DEF / TNEW_W_DEF : default register-address and Tnew/Tuse widths
//   FWD_*                   : forwarding select codes driven on fwd_rs_sel / fwd_rt_sel
//   TUSE_UNUSED             : Tuse value for an operand the D instruction never reads
package hazard_scoreboard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int TNEW_W_DEF = 2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    localparam logic [TNEW_W_DEF-1:0] TUSE_UNUSED = 2'd3;

endpackage

// File: rtl/hazard_entry_match.sv
// Compares one in-flight pipeline entry against one D-stage source operand.
//   ent_we_i, ent_rd_i, ent_tnew_i : entry contents (write enable, dest, cycles to result)
//   src_i, tuse_i                  : D-stage source register and cycles until it is needed
//   live_o   : entry will write src (register $0 never matches)
//   ready_o  : live and the result already exists, so it can be forwarded now
//   blocks_o : live and the result arrives after the operand is needed -> stall
module hazard_entry_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic              ent_we_i,
    input  logic [REG_AW-1:0] ent_rd_i,
    input  logic [TNEW_W-1:0] ent_tnew_i,
    input  logic [REG_AW-1:0] src_i,
    input  logic [TNEW_W-1:0] tuse_i,
    output logic              live_o,
    output logic              ready_o,
    output logic              blocks_o
);

    assign live_o   = ent_we_i && (ent_rd_i != '0) && (ent_rd_i == src_i);
    assign ready_o  = live_o && (ent_tnew_i == '0);
    assign blocks_o = live_o && (ent_tnew_i > tuse_i);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks register writes in flight in E/M/W and resolves D-stage RAW hazards.
//   clk, reset              : clock, asynchronous active-high reset
//   d_rs, d_rt              : D-stage source registers
//   d_rs_tuse, d_rt_tuse    : cycles until each source is needed (3 = unused)
//   d_rd, d_rd_we, d_tnew   : D-stage destination, its write enable, Tnew on entering E
//   stall                   : freeze PC and F/D, inject a bubble into E
//   fwd_rs_sel, fwd_rt_sel  : 0 regfile, 1 E, 2 M, 3 W
//   w_we, w_rd              : regfile write port driven from the W entry
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TNEW_W-1:0] d_rs_tuse,
    input  logic [TNEW_W-1:0] d_rt_tuse,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_rd_we,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              stall,
    output logic [1:0]        fwd_rs_sel,
    output logic [1:0]        fwd_rt_sel,
    output logic              w_we,
    output logic [REG_AW-1:0] w_rd
);

    localparam int NSTG = 3;   // index 0 = E, 1 = M, 2 = W (nearest first)
    localparam int NSRC = 2;   // index 0 = rs, 1 = rt

    logic [NSTG-1:0]             we_q,   we_d;
    logic [NSTG-1:0][REG_AW-1:0] rd_q,   rd_d;
    logic [NSTG-1:0][TNEW_W-1:0] tnew_q, tnew_d;

    logic [NSRC-1:0][REG_AW-1:0] src;
    logic [NSRC-1:0][TNEW_W-1:0] tuse;
    logic [NSRC-1:0][NSTG-1:0]   live, ready, blocks;
    logic [NSRC-1:0][1:0]        sel;

    assign src  = {d_rt, d_rs};
    assign tuse = {d_rt_tuse, d_rs_tuse};

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        for (genvar g = 0; g < NSTG; g++) begin : g_stg
            hazard_entry_match #(.REG_AW(REG_AW), .TNEW_W(TNEW_W)) u_match (
                .ent_we_i   (we_q[g]),
                .ent_rd_i   (rd_q[g]),
                .ent_tnew_i (tnew_q[g]),
                .src_i      (src[s]),
                .tuse_i     (tuse[s]),
                .live_o     (live[s][g]),
                .ready_o    (ready[s][g]),
                .blocks_o   (blocks[s][g])
            );
        end
    end

    // Only the nearest live producer holds the youngest value; if it is not
    // ready yet, an older ready copy further down is stale and must not be used.
    always_comb begin
        sel = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (live[s][0])      sel[s] = ready[s][0] ? FWD_E : FWD_RF;
            else if (live[s][1]) sel[s] = ready[s][1] ? FWD_M : FWD_RF;
            else if (live[s][2]) sel[s] = ready[s][2] ? FWD_W : FWD_RF;
        end
    end

    assign stall      = |blocks;
    assign fwd_rs_sel = sel[0];
    assign fwd_rt_sel = sel[1];
    assign w_we       = we_q[2] && (rd_q[2] != '0);
    assign w_rd       = rd_q[2];

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // E takes the D instruction or a bubble; M and W always advance, one
    // cycle of Tnew elapsing on each hop.
    always_comb begin
        we_d   = '0;
        rd_d   = '0;
        tnew_d = '0;
        if (!stall) begin
            we_d[0]   = d_rd_we;
            rd_d[0]   = d_rd;
            tnew_d[0] = d_tnew;
        end
        for (int g = 1; g < NSTG; g++) begin
            we_d[g]   = we_q[g-1];
            rd_d[g]   = rd_q[g-1];
            tnew_d[g] = sat_dec(tnew_q[g-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= '0;
            rd_q   <= '0;
            tnew_q <= '0;
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_d;
            tnew_q <= tnew_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_rd;
    logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_rd_we;
    logic       stall;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic       w_we;
    logic [4:0] w_rd;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_rd       (d_rd),
        .d_rd_we    (d_rd_we),
        .d_tnew     (d_tnew),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .w_we       (w_we),
        .w_rd       (w_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rs, rs_tuse, rt, rt_tuse, rd, rd_we, tnew
    task automatic drive(input logic [4:0] rs, input logic [1:0] rsu,
                         input logic [4:0] rt, input logic [1:0] rtu,
                         input logic [4:0] rd, input logic we, input logic [1:0] tn);
        d_rs = rs; d_rs_tuse = rsu; d_rt = rt; d_rt_tuse = rtu;
        d_rd = rd; d_rd_we = we; d_tnew = tn;
        #1;
    endtask

    task automatic idle();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_rs_sel", fwd_rs_sel, 0);
        chk("rst_rt_sel", fwd_rt_sel, 0);
        chk("rst_w_we", w_we, 0);
        chk("rst_w_rd", w_rd, 0);
        reset = 1'b0;
        tick();

        // ALU -> ALU on $8
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd1);
        tick();                                   // E={1,$8,1}
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 1'b1, 2'd1);
        chk("alu_e_stall", stall, 0);
        chk("alu_e_sel", fwd_rs_sel, 0);          // nearest not ready yet
        tick();                                   // E={$10,1} M={$8,0}
        drive(5'd8, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        chk("alu_m_stall", stall, 0);
        chk("alu_m_sel", fwd_rs_sel, 2);
        tick();                                   // W={$8,0}
        chk("alu_w_sel", fwd_rs_sel, 3);
        chk("alu_w_we", w_we, 1);
        chk("alu_w_rd", w_rd, 8);

        // Tnew 0 producer (jal) forwards from E
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 1'b1, 2'd0);
        tick();
        drive(5'd0, 2'd3, 5'd31, 2'd0, 5'd0, 1'b0, 2'd0);
        chk("jal_stall", stall, 0);
        chk("jal_rt_sel", fwd_rt_sel, 1);
        idle();
        repeat (3) tick();

        // load-use on $9, consumer tuse 0 -> 2 stall cycles
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd2);
        tick();                                   // E={$9,2}
        drive(5'd9, 2'd0, 5'd0, 2'd0, 5'd12, 1'b1, 2'd1);
        chk("lu_stall1", stall, 1);
        chk("lu_sel1", fwd_rs_sel, 0);
        tick();                                   // M={$9,1}
        chk("lu_stall2", stall, 1);
        tick();                                   // W={$9,0}
        chk("lu_stall3", stall, 0);
        chk("lu_sel3", fwd_rs_sel, 3);
        chk("lu_rt0_sel", fwd_rt_sel, 0);
        chk("lu_w_rd", w_rd, 9);
        tick();                                   // consumer now in E
        idle();
        chk("lu_bub1_w_we", w_we, 0);
        tick();
        chk("lu_bub2_w_we", w_we, 0);
        tick();
        chk("lu_cons_w_we", w_we, 1);
        chk("lu_cons_w_rd", w_rd, 12);

        // load-use with tuse 1 -> 1 stall cycle
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd2);
        tick();
        drive(5'd9, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        chk("lu1_stall1", stall, 1);
        tick();
        chk("lu1_stall2", stall, 0);
        chk("lu1_sel2", fwd_rs_sel, 0);
        idle();
        repeat (3) tick();

        // $0 never matches
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2);
        tick();
        drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        chk("z_stall", stall, 0);
        chk("z_rs_sel", fwd_rs_sel, 0);
        tick();
        tick();                                   // lw $0 in W
        chk("z_w_we", w_we, 0);
        idle();
        tick();

        // priority: nearer not-ready beats farther ready
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd1);
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd1);
        tick();                                   // E={$5,1} M={$5,0}
        drive(5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        chk("pri_stall", stall, 0);
        chk("pri_sel_e", fwd_rs_sel, 0);
        tick();                                   // M={$5,0} W={$5,0}
        chk("pri_sel_m", fwd_rs_sel, 2);
        idle();
        repeat (3) tick();

        // W bypass on rt=$3, plus unused rt against a live load
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 1'b1, 2'd1);
        tick();
        idle();
        tick();
        tick();                                   // W={1,$3,0}
        drive(5'd0, 2'd3, 5'd3, 2'd0, 5'd0, 1'b0, 2'd0);
        chk("wb_rt_sel", fwd_rt_sel, 3);
        chk("wb_w_we", w_we, 1);
        chk("wb_w_rd", w_rd, 3);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 1'b1, 2'd2);
        tick();
        drive(5'd0, 2'd3, 5'd4, 2'd3, 5'd0, 1'b0, 2'd0);
        chk("unused_stall", stall, 0);

        // mid-run reset with live entries
        idle();
        repeat (3) tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 1'b1, 2'd1);
        tick();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 1'b1, 2'd2);
        tick();                                   // E={$6,2} M={$7,0}
        drive(5'd6, 2'd0, 5'd7, 2'd0, 5'd0, 1'b0, 2'd0);
        chk("mr_pre_stall", stall, 1);
        chk("mr_pre_rt_sel", fwd_rt_sel, 2);
        reset = 1'b1;
        #1;
        chk("mr_stall", stall, 0);
        chk("mr_rs_sel", fwd_rs_sel, 0);
        chk("mr_rt_sel", fwd_rt_sel, 0);
        chk("mr_w_we", w_we, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mr_rel_stall", stall, 0);
        chk("mr_rel_rt_sel", fwd_rt_sel, 0);
        tick();
        chk("mr_rel_w_we", w_we, 0);
        tick();
        chk("mr_rel_w_we2", w_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
